// File: rtl/exe_stage_if.sv
// exe_stage_if: bundle between the decode stage, the execute stage and the memory stage.
//   slave  modport (execute stage): takes the ID-side *_IN fields; drives the *_OUT fields,
//                                   the EXE->ID bypass triple and WANT_FREEZE.
//   master modport (ID/MEM side):   drives the *_IN fields; observes everything else.
interface exe_stage_if;
   logic [31:0] Instr1_IN;
   logic [31:0] Instr1_PC_IN;
   logic [31:0] OperandA1_IN;
   logic [31:0] OperandB1_IN;
   logic [4:0]  WriteRegister1_IN;
   logic [31:0] MemWriteData1_IN;
   logic        RegWrite1_IN;
   logic [5:0]  ALU_Control1_IN;
   logic        MemRead1_IN;
   logic        MemWrite1_IN;
   logic [4:0]  ShiftAmount1_IN;

   logic [31:0] Instr1_OUT;
   logic [31:0] Instr1_PC_OUT;
   logic [31:0] ALUResult1_OUT;
   logic [4:0]  WriteRegister1_OUT;
   logic [31:0] MemWriteData1_OUT;
   logic        RegWrite1_OUT;
   logic [5:0]  ALU_Control1_OUT;
   logic        MemRead1_OUT;
   logic        MemWrite1_OUT;

   logic [4:0]  BypassReg1_EXEID;
   logic [31:0] BypassData1_EXEID;
   logic        BypassValid1_EXEID;
   logic        WANT_FREEZE;

   modport slave (
      input  Instr1_IN, Instr1_PC_IN, OperandA1_IN, OperandB1_IN, WriteRegister1_IN,
             MemWriteData1_IN, RegWrite1_IN, ALU_Control1_IN, MemRead1_IN, MemWrite1_IN,
             ShiftAmount1_IN,
      output Instr1_OUT, Instr1_PC_OUT, ALUResult1_OUT, WriteRegister1_OUT, MemWriteData1_OUT,
             RegWrite1_OUT, ALU_Control1_OUT, MemRead1_OUT, MemWrite1_OUT,
             BypassReg1_EXEID, BypassData1_EXEID, BypassValid1_EXEID, WANT_FREEZE
   );

   modport master (
      output Instr1_IN, Instr1_PC_IN, OperandA1_IN, OperandB1_IN, WriteRegister1_IN,
             MemWriteData1_IN, RegWrite1_IN, ALU_Control1_IN, MemRead1_IN, MemWrite1_IN,
             ShiftAmount1_IN,
      input  Instr1_OUT, Instr1_PC_OUT, ALUResult1_OUT, WriteRegister1_OUT, MemWriteData1_OUT,
             RegWrite1_OUT, ALU_Control1_OUT, MemRead1_OUT, MemWrite1_OUT,
             BypassReg1_EXEID, BypassData1_EXEID, BypassValid1_EXEID, WANT_FREEZE
   );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: single-issue execute stage.
//   CLK   - clock, posedge active
//   RESET - asynchronous active-low reset
//   bus   - exe_stage_if.slave: ID-side inputs, registered MEM-side outputs, EXE->ID bypass
//           triple and the combinational WANT_FREEZE stall request.
// ALU/shift results are registered with one cycle of latency. An iterative MULT/DIV unit
// owns HI/LO; HI/LO-touching instructions stall (bubble out) while it is busy.
module exe_stage #(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_ITERS  = 32
) (
   input logic        CLK,
   input logic        RESET,
   exe_stage_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
   logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

   logic [31:0] instr_q, pc_q, res_q, mwd_q;
   logic [4:0]  wr_q;
   logic        rw_q, mr_q, mw_q;
   logic [5:0]  alu_q;

   logic [31:0] a, b, alu_res, a_mag, b_mag;
   logic [5:0]  op;
   logic [4:0]  shamt;
   logic        busy, is_hilo, freeze, issue, sgn;
   logic [32:0] div_shift, div_diff;

   assign a       = bus.OperandA1_IN;
   assign b       = bus.OperandB1_IN;
   assign op      = bus.ALU_Control1_IN;
   assign shamt   = bus.ShiftAmount1_IN;
   assign busy    = (state_q != StIdle);
   assign is_hilo = (op >= 6'd16) && (op <= 6'd23);
   assign freeze  = busy & is_hilo;
   assign issue   = ~freeze;
   // Even codes in the MULT/DIV group are the signed variants.
   assign sgn     = (op == 6'd20) || (op == 6'd22);
   assign a_mag   = (sgn && a[31]) ? (~a + 32'd1) : a;
   assign b_mag   = (sgn && b[31]) ? (~b + 32'd1) : b;

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   assign div_shift = {rem_q, quo_q[31]};
   assign div_diff  = div_shift - {1'b0, dvs_q};

   always_comb begin
      alu_res = a + b;
      case (op)
         6'd0:  alu_res = '0;
         6'd1:  alu_res = a + b;
         6'd2:  alu_res = a - b;
         6'd3:  alu_res = a & b;
         6'd4:  alu_res = a | b;
         6'd5:  alu_res = a ^ b;
         6'd6:  alu_res = ~(a | b);
         6'd7:  alu_res = {31'b0, $signed(a) < $signed(b)};
         6'd8:  alu_res = {31'b0, a < b};
         6'd9:  alu_res = b << shamt;
         6'd10: alu_res = b >> shamt;
         6'd11: alu_res = $unsigned($signed(b) >>> shamt);
         6'd12: alu_res = b << a[4:0];
         6'd13: alu_res = b >> a[4:0];
         6'd14: alu_res = $unsigned($signed(b) >>> a[4:0]);
         6'd15: alu_res = b << 16;
         6'd16: alu_res = hi_q;
         6'd17: alu_res = lo_q;
         6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23: alu_res = '0;
         default: alu_res = a + b;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      prod_d    = prod_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      dvd_d     = dvd_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;

      unique case (state_q)
         StIdle: begin
            if (issue && (op == 6'd18)) hi_d = a;
            if (issue && (op == 6'd19)) lo_d = a;
            if (issue && ((op == 6'd20) || (op == 6'd21))) begin
               // Low 64 bits of the extended product are right for both signednesses.
               prod_d  = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
               cnt_d   = 6'(MUL_CYCLES - 1);
               state_d = StMul;
            end
            if (issue && ((op == 6'd22) || (op == 6'd23))) begin
               rem_d     = '0;
               quo_d     = a_mag;
               dvs_d     = b_mag;
               dvd_d     = a;
               dz_d      = (b == 32'd0);
               neg_quo_d = sgn & (a[31] ^ b[31]);
               neg_rem_d = sgn & a[31];
               cnt_d     = '0;
               state_d   = StDiv;
            end
         end
         StMul: begin
            if (cnt_q == 6'd0) begin
               {hi_d, lo_d} = prod_q;
               state_d      = StIdle;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         StDiv: begin
            if (!div_diff[32]) begin
               rem_d = div_diff[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = div_shift[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(DIV_ITERS - 1)) state_d = StFix;
         end
         StFix: begin
            if (dz_q) begin
               lo_d = 32'hFFFF_FFFF;
               hi_d = dvd_q;
            end else begin
               lo_d = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
               hi_d = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         prod_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         dvd_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         prod_q    <= prod_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         dvd_q     <= dvd_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
      end
   end

   // Result bundle toward MEM; a frozen cycle emits a bubble with PC/dest/store data held.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         instr_q <= '0;
         pc_q    <= '0;
         res_q   <= '0;
         wr_q    <= '0;
         mwd_q   <= '0;
         rw_q    <= 1'b0;
         alu_q   <= '0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
      end else if (freeze) begin
         instr_q <= '0;
         res_q   <= '0;
         rw_q    <= 1'b0;
         alu_q   <= '0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
      end else begin
         instr_q <= bus.Instr1_IN;
         pc_q    <= bus.Instr1_PC_IN;
         res_q   <= alu_res;
         wr_q    <= bus.WriteRegister1_IN;
         mwd_q   <= bus.MemWriteData1_IN;
         rw_q    <= bus.RegWrite1_IN & (bus.WriteRegister1_IN != 5'd0);
         alu_q   <= op;
         mr_q    <= bus.MemRead1_IN;
         mw_q    <= bus.MemWrite1_IN;
      end
   end

   assign bus.Instr1_OUT         = instr_q;
   assign bus.Instr1_PC_OUT      = pc_q;
   assign bus.ALUResult1_OUT     = res_q;
   assign bus.WriteRegister1_OUT = wr_q;
   assign bus.MemWriteData1_OUT  = mwd_q;
   assign bus.RegWrite1_OUT      = rw_q;
   assign bus.ALU_Control1_OUT   = alu_q;
   assign bus.MemRead1_OUT       = mr_q;
   assign bus.MemWrite1_OUT      = mw_q;
   // Loads are not bypassable from EXE: the data only exists after MEM.
   assign bus.BypassReg1_EXEID   = wr_q;
   assign bus.BypassData1_EXEID  = res_q;
   assign bus.BypassValid1_EXEID = rw_q & ~mr_q;
   assign bus.WANT_FREEZE        = freeze;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

   localparam int unsigned MulCycles = 4;
   localparam int unsigned DivEdges  = 33;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   always #5 CLK = ~CLK;

   exe_stage_if u_if ();

   exe_stage #(
      .MUL_CYCLES(MulCycles),
      .DIV_ITERS (32)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (u_if)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] res;
      logic [4:0]  wr;
      logic [31:0] mwd;
      logic        rw;
      logic [5:0]  alu;
      logic        mr;
      logic        mw;
      logic [4:0]  breg;
      logic [31:0] bdata;
      logic        bv;
   } out_t;

   out_t  exp_q[$];
   string tag_q[$];
   int    n_vec = 0;
   int    n_bad = 0;

   // Reference model state: architectural HI/LO plus a pending unit result.
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int          m_busy = 0;
   out_t        m_last = '0;

   function automatic out_t get_out();
      out_t o;
      o.instr = u_if.Instr1_OUT;
      o.pc    = u_if.Instr1_PC_OUT;
      o.res   = u_if.ALUResult1_OUT;
      o.wr    = u_if.WriteRegister1_OUT;
      o.mwd   = u_if.MemWriteData1_OUT;
      o.rw    = u_if.RegWrite1_OUT;
      o.alu   = u_if.ALU_Control1_OUT;
      o.mr    = u_if.MemRead1_OUT;
      o.mw    = u_if.MemWrite1_OUT;
      o.breg  = u_if.BypassReg1_EXEID;
      o.bdata = u_if.BypassData1_EXEID;
      o.bv    = u_if.BypassValid1_EXEID;
      return o;
   endfunction

   task automatic chk(input string tag, input out_t got, input out_t exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got instr=%h pc=%h res=%h wr=%0d mwd=%h rw=%b alu=%0d mr=%b mw=%b byp=%0d/%h/%b required instr=%h pc=%h res=%h wr=%0d mwd=%h rw=%b alu=%0d mr=%b mw=%b byp=%0d/%h/%b",
                  tag, got.instr, got.pc, got.res, got.wr, got.mwd, got.rw, got.alu, got.mr,
                  got.mw, got.breg, got.bdata, got.bv, exp.instr, exp.pc, exp.res, exp.wr,
                  exp.mwd, exp.rw, exp.alu, exp.mr, exp.mw, exp.breg, exp.bdata, exp.bv);
      end
   endtask

   task automatic chk_bit(input string tag, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b required %b", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
      int sa, sb;
      sa = a;
      sb = b;
      case (op)
         0:  return 32'd0;
         1:  return a + b;
         2:  return a - b;
         3:  return a & b;
         4:  return a | b;
         5:  return a ^ b;
         6:  return ~(a | b);
         7:  return (sa < sb) ? 32'd1 : 32'd0;
         8:  return (a < b) ? 32'd1 : 32'd0;
         9:  return b << sh;
         10: return b >> sh;
         11: return 32'(sb >>> sh);
         12: return b << a[4:0];
         13: return b >> a[4:0];
         14: return 32'(sb >>> a[4:0]);
         15: return {b[15:0], 16'h0};
         16: return m_hi;
         17: return m_lo;
         18, 19, 20, 21, 22, 23: return 32'd0;
         default: return a + b;
      endcase
   endfunction

   // {HI, LO} for MULT/MULTU/DIV/DIVU from plain wide arithmetic.
   function automatic logic [63:0] ref_unit(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == 20) begin
         p = 64'(sa * sb);
         return p;
      end
      if (op == 21) begin
         p = {32'h0, a} * {32'h0, b};
         return p;
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == 22) begin
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] wr,
                        input logic [31:0] mwd, input logic rw, input logic [5:0] op,
                        input logic mr, input logic mw, input logic [4:0] sh);
      int   tries;
      logic frz;
      out_t e;
      logic [63:0] u;
      tries = 0;
      do begin
         @(negedge CLK);
         u_if.Instr1_IN         = instr;
         u_if.Instr1_PC_IN      = pc;
         u_if.OperandA1_IN      = a;
         u_if.OperandB1_IN      = b;
         u_if.WriteRegister1_IN = wr;
         u_if.MemWriteData1_IN  = mwd;
         u_if.RegWrite1_IN      = rw;
         u_if.ALU_Control1_IN   = op;
         u_if.MemRead1_IN       = mr;
         u_if.MemWrite1_IN      = mw;
         u_if.ShiftAmount1_IN   = sh;
         #1;
         frz = (m_busy > 0) && (op >= 16) && (op <= 23);
         chk_bit({"freeze ", tag}, u_if.WANT_FREEZE, frz);
         if (frz) begin
            e       = m_last;
            e.instr = '0;
            e.res   = '0;
            e.rw    = 1'b0;
            e.alu   = '0;
            e.mr    = 1'b0;
            e.mw    = 1'b0;
         end else begin
            e.instr = instr;
            e.pc    = pc;
            e.res   = ref_alu(op, a, b, sh);
            e.wr    = wr;
            e.mwd   = mwd;
            e.rw    = rw && (wr != 0);
            e.alu   = op;
            e.mr    = mr;
            e.mw    = mw;
         end
         e.breg  = e.wr;
         e.bdata = e.res;
         e.bv    = e.rw && !e.mr;
         exp_q.push_back(e);
         tag_q.push_back(tag);
         m_last = e;
         // Advance the model across the coming edge.
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_hi = p_hi;
               m_lo = p_lo;
            end
         end
         if (!frz) begin
            if (op == 18) m_hi = a;
            if (op == 19) m_lo = a;
            if (op >= 20 && op <= 23) begin
               u      = ref_unit(op, a, b);
               p_hi   = u[63:32];
               p_lo   = u[31:0];
               m_busy = (op <= 21) ? int'(MulCycles) : int'(DivEdges);
            end
         end
         tries++;
      end while (frz && tries < 64);
      if (frz) chk_bit({"freeze bound ", tag}, 1'b1, 1'b0);
   endtask

   task automatic alu_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wr, input logic [4:0] sh);
      issue(tag, {26'h0, op}, 32'h0040_0000 + 32'(n_vec), a, b, wr, 32'h0, 1'b1, op, 1'b0,
            1'b0, sh);
   endtask

   // Monitor: every DUT output cycle is checked against the next scoreboard entry.
   initial begin
      out_t  e;
      string t;
      forever begin
         @(posedge CLK);
         #1;
         if (RESET && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, get_out(), e);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish, %0d scoreboard entries left",
               exp_q.size());
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ra, rb;
      logic [5:0]  rop;
      int          r;
      u_if.Instr1_IN = '0; u_if.Instr1_PC_IN = '0; u_if.OperandA1_IN = '0;
      u_if.OperandB1_IN = '0; u_if.WriteRegister1_IN = '0; u_if.MemWriteData1_IN = '0;
      u_if.RegWrite1_IN = 1'b0; u_if.ALU_Control1_IN = '0; u_if.MemRead1_IN = 1'b0;
      u_if.MemWrite1_IN = 1'b0; u_if.ShiftAmount1_IN = '0;
      #2;
      chk("reset outputs", get_out(), '0);
      chk_bit("reset freeze", u_if.WANT_FREEZE, 1'b0);
      @(negedge CLK);
      RESET = 1'b1;

      alu_op("add overflow", 6'd1, 32'h7FFF_FFFF, 32'h1, 5'd5, 5'd0);
      alu_op("add wr0", 6'd1, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd0);
      alu_op("sra", 6'd11, 32'h0, 32'hF000_0000, 5'd7, 5'd4);
      alu_op("sltu", 6'd8, 32'h1, 32'hFFFF_FFFF, 5'd8, 5'd0);
      alu_op("slt", 6'd7, 32'h1, 32'hFFFF_FFFF, 5'd9, 5'd0);
      alu_op("srav", 6'd14, 32'h0000_0024, 32'h8000_0000, 5'd3, 5'd0);
      alu_op("lui", 6'd15, 32'h0, 32'h0000_ABCD, 5'd3, 5'd0);
      alu_op("mult", 6'd20, 32'hFFFF_FFFE, 32'h3, 5'd0, 5'd0);
      alu_op("mflo after mult", 6'd17, 32'h0, 32'h0, 5'd10, 5'd0);
      alu_op("mfhi after mult", 6'd16, 32'h0, 32'h0, 5'd11, 5'd0);
      alu_op("div", 6'd22, 32'hFFFF_FFF9, 32'h2, 5'd0, 5'd0);
      alu_op("flow while busy", 6'd5, 32'h1234_5678, 32'hFFFF_0000, 5'd12, 5'd0);
      alu_op("mflo after div", 6'd17, 32'h0, 32'h0, 5'd13, 5'd0);
      alu_op("mfhi after div", 6'd16, 32'h0, 32'h0, 5'd14, 5'd0);
      alu_op("divu by zero", 6'd23, 32'h1234_5678, 32'h0, 5'd0, 5'd0);
      alu_op("mflo div0", 6'd17, 32'h0, 32'h0, 5'd15, 5'd0);
      alu_op("mfhi div0", 6'd16, 32'h0, 32'h0, 5'd15, 5'd0);
      alu_op("div min/-1", 6'd22, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 5'd0);
      alu_op("mflo min/-1", 6'd17, 32'h0, 32'h0, 5'd16, 5'd0);
      alu_op("mfhi min/-1", 6'd16, 32'h0, 32'h0, 5'd16, 5'd0);
      alu_op("mthi", 6'd18, 32'hCAFE_F00D, 32'h0, 5'd0, 5'd0);
      alu_op("mfhi after mthi", 6'd16, 32'h0, 32'h0, 5'd17, 5'd0);
      issue("lw", 32'h8C00_0000, 32'h0040_1000, 32'h0000_1000, 32'hFFFF_FFFC, 5'd18, 32'h0,
            1'b1, 6'd24, 1'b1, 1'b0, 5'd0);
      issue("sw", 32'hAC00_0000, 32'h0040_1004, 32'h0000_2000, 32'h8, 5'd0, 32'hDEAD_BEEF,
            1'b0, 6'd25, 1'b0, 1'b1, 5'd0);
      issue("syscall", 32'h0000_000C, 32'h0040_1008, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 6'd30,
            1'b0, 1'b0, 5'd0);

      // Abort a division in flight with reset.
      alu_op("div before reset", 6'd22, 32'h7654_3210, 32'h3, 5'd0, 5'd0);
      for (int i = 0; i < 9; i++) alu_op("add during div", 6'd1, 32'(i), 32'h10, 5'd2, 5'd0);
      @(negedge CLK);
      u_if.ALU_Control1_IN = 6'd16;
      RESET = 1'b0;
      #1;
      chk("mid-div reset outputs", get_out(), '0);
      chk_bit("mid-div reset freeze", u_if.WANT_FREEZE, 1'b0);
      m_hi = '0; m_lo = '0; m_busy = 0; m_last = '0;
      @(negedge CLK);
      RESET = 1'b1;
      alu_op("mfhi after reset", 6'd16, 32'h0, 32'h0, 5'd4, 5'd0);
      alu_op("mflo after reset", 6'd17, 32'h0, 32'h0, 5'd4, 5'd0);

      for (int n = 0; n < 500; n++) begin
         r   = $urandom_range(0, 99);
         rop = (r < 75) ? 6'($urandom_range(0, 23)) : 6'($urandom_range(24, 63));
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         issue("random", $urandom, $urandom, ra, rb, 5'($urandom_range(0, 31)), $urandom,
               1'($urandom), rop, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)));
      end

      @(posedge CLK);
      #2;
      if (exp_q.size() != 0) chk_bit("scoreboard drained", 1'b0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
